// File: rtl/alu_spi_sequencer.sv
// alu_spi_sequencer: fetches two operands from a register file, ships
// {opcode, opA, opB} to an external ALU over an SPI mode-0 link, collects the
// serial result and writes it back to the register file.
module alu_spi_sequencer #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 10,
    parameter int SCLK_DIV   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [2+3*REG_ADDR_W-1:0]   instr,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    output logic                        busy,
    output logic                        done,
    output logic [REG_ADDR_W-1:0]       rf_raddr,
    input  logic [DATA_W-1:0]           rf_rdata,
    output logic                        rf_we,
    output logic [REG_ADDR_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic                        spi_cs_n,
    output logic                        spi_sclk,
    output logic                        spi_mosi,
    input  logic                        spi_miso
);

    localparam int INSTR_W   = 2 + 3*REG_ADDR_W;
    localparam int HOLD_W    = 2 + 2*REG_ADDR_W;   // opcode, regB, rd
    localparam int TX_W      = 2 + 2*DATA_W;
    localparam int PERIODS   = 3*DATA_W + 2;
    localparam int RX_FIRST  = 2*DATA_W + 2;       // first result period, 0-based
    localparam int BIT_CNT_W = $clog2(PERIODS + 1);
    localparam int DIV_CNT_W = $clog2(SCLK_DIV + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_LATCH = 3'd3,
        ST_XFER  = 3'd4,
        ST_WB    = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [HOLD_W-1:0]      instr_r;
    logic [DATA_W-1:0]      opa_r;
    logic [TX_W-1:0]        tx_r;
    logic [DATA_W-1:0]      rx_r;
    logic [DIV_CNT_W-1:0]   div_cnt_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic [1:0]             opcode_s;
    logic [REG_ADDR_W-1:0]  rb_s;
    logic [REG_ADDR_W-1:0]  rd_s;
    logic                   half_end_s;
    logic                   fall_s;
    logic                   last_s;

    assign opcode_s   = instr_r[HOLD_W-1 -: 2];
    assign rb_s       = instr_r[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rd_s       = instr_r[REG_ADDR_W-1:0];
    assign half_end_s = (div_cnt_r == DIV_CNT_W'(SCLK_DIV - 1));
    assign fall_s     = (state_r == ST_XFER) && half_end_s && spi_sclk;
    assign last_s     = (bit_cnt_r == BIT_CNT_W'(PERIODS - 1));
    assign spi_mosi   = tx_r[TX_W-1];

    // Next-state decode of the operation sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_s = ST_RD_A;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_A:  state_s = ST_RD_B;
            ST_RD_B:  state_s = ST_LATCH;
            ST_LATCH: state_s = ST_XFER;
            ST_XFER: begin
                if (fall_s && last_s) begin
                    state_s = ST_WB;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_WB:    state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake, write strobe and chip select registered from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            rf_we       <= 1'b0;
            spi_cs_n    <= 1'b1;
        end else begin
            instr_ready <= (state_s == ST_IDLE);
            busy        <= (state_s != ST_IDLE);
            done        <= (state_s == ST_WB);
            rf_we       <= (state_s == ST_WB);
            spi_cs_n    <= (state_s != ST_XFER);
        end
    end

    // Instruction capture, operand read addressing and write-back data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_r  <= '0;
            opa_r    <= '0;
            rf_raddr <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_r  <= {instr[INSTR_W-1 -: 2], instr[2*REG_ADDR_W-1:0]};
                        rf_raddr <= instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
                    end
                end
                ST_RD_A: rf_raddr <= rb_s;
                ST_RD_B: opa_r    <= rf_rdata;
                ST_XFER: begin
                    if (state_s == ST_WB) begin
                        rf_waddr <= rd_s;
                        rf_wdata <= rx_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // SPI mode-0 engine: SCLK divider, MOSI shift-out, MISO shift-in
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_r      <= '0;
            rx_r      <= '0;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            spi_sclk  <= 1'b0;
        end else if (state_r == ST_LATCH) begin
            // opB is taken straight from the read port into the frame
            tx_r      <= {opcode_s, opa_r, rf_rdata};
            rx_r      <= '0;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            spi_sclk  <= 1'b0;
        end else if (state_r == ST_XFER) begin
            if (half_end_s) begin
                div_cnt_r <= '0;
                spi_sclk  <= ~spi_sclk;
                if (!spi_sclk) begin
                    // rising SCLK: only the trailing DATA_W periods carry the result
                    if (bit_cnt_r >= BIT_CNT_W'(RX_FIRST)) begin
                        rx_r <= {rx_r[DATA_W-2:0], spi_miso};
                    end
                end else begin
                    // falling SCLK: advance MOSI, zeros fill in behind the frame
                    tx_r      <= {tx_r[TX_W-2:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_CNT_W'(1);
            end
        end else begin
            spi_sclk <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_spi_sequencer.sv
// Bench for alu_spi_sequencer: two instances (SCLK_DIV=2 and SCLK_DIV=1),
// a synchronous-read register file, an SPI-slave ALU model and a reference
// register file used to predict every write-back.
module tb_alu_spi_sequencer;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int IW  = 2 + 3*AW;
    localparam int TXW = 2 + 2*DW;
    localparam int PER = 3*DW + 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic          clock;
    logic          reset       [2];
    logic [IW-1:0] instr       [2];
    logic          instr_valid [2];
    logic          instr_ready [2];
    logic          busy        [2];
    logic          done        [2];
    logic [AW-1:0] rf_raddr    [2];
    logic [DW-1:0] rf_rdata    [2];
    logic          rf_we       [2];
    logic [AW-1:0] rf_waddr    [2];
    logic [DW-1:0] rf_wdata    [2];
    logic          spi_cs_n    [2];
    logic          spi_sclk    [2];
    logic          spi_mosi    [2];
    logic          spi_miso    [2];

    logic [DW-1:0] rf_mem   [2][1024];
    logic [DW-1:0] ref_mem  [2][1024];
    logic          tb_we    [2];
    logic [AW-1:0] tb_waddr [2];
    logic [DW-1:0] tb_wdata [2];

    int            rises     [2];
    logic [TXW-1:0] cap      [2];
    logic          tail_nz   [2];
    logic [DW-1:0] alu_res   [2];
    logic          prev_sclk [2];
    logic          prev_cs   [2];

    int n_total = 0;
    int n_pass  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_spi_sequencer #(
            .DATA_W(DW), .REG_ADDR_W(AW), .SCLK_DIV((g == 0) ? 2 : 1)
        ) u_dut (
            .clock(clock), .reset(reset[g]),
            .instr(instr[g]), .instr_valid(instr_valid[g]),
            .instr_ready(instr_ready[g]), .busy(busy[g]), .done(done[g]),
            .rf_raddr(rf_raddr[g]), .rf_rdata(rf_rdata[g]),
            .rf_we(rf_we[g]), .rf_waddr(rf_waddr[g]), .rf_wdata(rf_wdata[g]),
            .spi_cs_n(spi_cs_n[g]), .spi_sclk(spi_sclk[g]),
            .spi_mosi(spi_mosi[g]), .spi_miso(spi_miso[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] alu(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // Register files: one-cycle read latency, DUT write port, bench preload port
    always @(posedge clock) begin
        for (int g = 0; g < 2; g++) begin
            rf_rdata[g] <= rf_mem[g][rf_raddr[g]];
            if (rf_we[g]) rf_mem[g][rf_waddr[g]] <= rf_wdata[g];
            else if (tb_we[g]) rf_mem[g][tb_waddr[g]] <= tb_wdata[g];
        end
    end

    // SPI-slave ALU: collects the frame on rising SCLK, answers after falling SCLK
    always @(negedge clock) begin : p_alu
        int r;
        logic [TXW-1:0] c;
        logic [DW-1:0] v;
        logic t;
        for (int g = 0; g < 2; g++) begin
            r = rises[g]; c = cap[g]; v = alu_res[g]; t = tail_nz[g];
            if (!spi_cs_n[g] && prev_cs[g]) begin
                r = 0; c = '0; t = 1'b0;
            end
            if (spi_sclk[g] && !prev_sclk[g]) begin
                r = r + 1;
                if (r <= TXW) c = {c[TXW-2:0], spi_mosi[g]};
                else if (spi_mosi[g]) t = 1'b1;
                if (r == TXW) v = alu(c[TXW-1 -: 2], c[TXW-3 -: DW], c[DW-1:0]);
            end
            if (!spi_sclk[g] && prev_sclk[g]) begin
                if (r >= TXW && r < TXW + DW) spi_miso[g] <= v[DW-1-(r-TXW)];
                else spi_miso[g] <= 1'($urandom_range(1, 0));
            end
            rises[g]     <= r;
            cap[g]       <= c;
            alu_res[g]   <= v;
            tail_nz[g]   <= t;
            prev_sclk[g] <= spi_sclk[g];
            prev_cs[g]   <= spi_cs_n[g];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic poke(input int g, input logic [AW-1:0] a, input logic [DW-1:0] v);
        tb_we[g] = 1'b1; tb_waddr[g] = a; tb_wdata[g] = v;
        ref_mem[g][a] = v;
        step();
        tb_we[g] = 1'b0;
    endtask

    // One instruction end to end; inject_at >= 0 pulses a foreign instruction
    // during the op, abort_at > 0 resets the DUT at that SCLK period.
    task automatic run_op(input int g, input logic [1:0] op, input logic [AW-1:0] ra,
                          input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                          input int inject_at, input int abort_at);
        int d = (g == 0) ? 2 : 1;
        int lat_exp = 3 + 2*d*PER;
        int lat = 0;
        int cslow = 0;
        bit found = 1'b0;
        logic [DW-1:0] a = ref_mem[g][ra];
        logic [DW-1:0] b = ref_mem[g][rb];
        logic [DW-1:0] exp = alu(op, a, b);
        chk("ready_before_accept", instr_ready[g], 1'b1);
        instr[g] = {op, ra, rb, rd};
        instr_valid[g] = 1'b1;
        for (int k = 0; k < lat_exp + 50; k++) begin
            step();
            if (k == 0) begin
                instr_valid[g] = 1'b0;
                instr[g] = IW'($urandom);
                chk("busy_ready_after_accept", {busy[g], instr_ready[g]}, 2'b10);
            end
            if (k == inject_at) begin
                instr_valid[g] = 1'b1;
                instr[g] = {~op, ~ra, ~rb, ~rd};
            end
            if (k == inject_at + 1) instr_valid[g] = 1'b0;
            if (abort_at > 0 && rises[g] == abort_at) begin
                reset[g] = 1'b0;
                #1;
                chk("abort_async", {spi_cs_n[g], spi_sclk[g], rf_we[g], instr_ready[g], busy[g], done[g]}, 6'b100100);
                step();
                chk("abort_held", {spi_cs_n[g], spi_sclk[g], rf_we[g], instr_ready[g], busy[g], done[g]}, 6'b100100);
                reset[g] = 1'b1;
                return;
            end
            if (!spi_cs_n[g]) cslow++;
            if (rf_we[g]) begin
                lat = k;
                found = 1'b1;
                break;
            end
        end
        chk("wb_seen", found, 1'b1);
        if (!found) return;
        chk("wb_latency", lat, lat_exp);
        chk("wb_done_busy_cs_sclk", {done[g], busy[g], spi_cs_n[g], spi_sclk[g]}, 4'b1110);
        chk("wb_waddr", rf_waddr[g], rd);
        chk("wb_wdata", rf_wdata[g], exp);
        chk("cs_low_cycles", cslow, 2*d*PER);
        chk("sclk_periods", rises[g], PER);
        chk("mosi_frame", cap[g], {op, a, b});
        chk("mosi_tail_zero", tail_nz[g], 1'b0);
        ref_mem[g][rd] = exp;
        step();
        chk("after_wb", {rf_we[g], done[g], instr_ready[g], busy[g]}, 4'b0010);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            reset[g] = 1'b0; instr[g] = '0; instr_valid[g] = 1'b0;
            tb_we[g] = 1'b0; tb_waddr[g] = '0; tb_wdata[g] = '0;
        end
        step();
        step();
        for (int g = 0; g < 2; g++) begin
            chk("reset_state", {instr_ready[g], busy[g], done[g], rf_we[g], rf_raddr[g], rf_waddr[g],
                                rf_wdata[g], spi_cs_n[g], spi_sclk[g], spi_mosi[g]},
                {1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0});
            reset[g] = 1'b1;
        end
        for (int a = 0; a < 1024; a++) begin
            for (int g = 0; g < 2; g++) begin
                tb_we[g] = 1'b1; tb_waddr[g] = AW'(a); tb_wdata[g] = $urandom;
                ref_mem[g][a] = tb_wdata[g];
            end
            step();
        end
        for (int g = 0; g < 2; g++) tb_we[g] = 1'b0;

        // ADD 5 + 3 into r3
        poke(0, 10'd1, 32'd5);
        poke(0, 10'd2, 32'd3);
        run_op(0, OP_ADD, 10'd1, 10'd2, 10'd3, -1, 0);
        // SUB frame content check
        poke(0, 10'd4, 32'hFFFF_0000);
        poke(0, 10'd5, 32'h0000_FFFF);
        run_op(0, OP_SUB, 10'd4, 10'd5, 10'd6, -1, 0);
        // Seven back-to-back ops all on r1023
        for (int i = 0; i < 7; i++)
            run_op(0, 2'($urandom_range(3, 0)), 10'd1023, 10'd1023, 10'd1023, -1, 0);
        // Foreign instruction pulsed mid-transfer
        run_op(0, 2'($urandom_range(3, 0)), AW'($urandom_range(1023, 0)),
               AW'($urandom_range(1023, 0)), AW'($urandom_range(1023, 0)), 150, 0);
        // Reset at SCLK period 50, then a normal op reading the untouched target
        run_op(0, OP_ADD, 10'd10, 10'd11, 10'd12, -1, 50);
        run_op(0, OP_SUB, 10'd12, 10'd10, 10'd13, -1, 0);
        for (int i = 0; i < 3; i++)
            run_op(0, 2'($urandom_range(3, 0)), AW'($urandom_range(1023, 0)),
                   AW'($urandom_range(1023, 0)), AW'($urandom_range(1023, 0)), -1, 0);

        // SCLK_DIV=1 instance
        poke(1, 10'd20, 32'hF0F0_F0F0);
        poke(1, 10'd21, 32'hFF00_FF00);
        run_op(1, OP_AND, 10'd20, 10'd21, 10'd22, -1, 0);
        for (int i = 0; i < 2; i++)
            run_op(1, 2'($urandom_range(3, 0)), AW'($urandom_range(1023, 0)),
                   AW'($urandom_range(1023, 0)), AW'($urandom_range(1023, 0)), -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_spi_sequencer.md
ALU_SPI_SEQUENCER -- requirements
Module: alu_spi_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: operand, result and register-file word width.
REQ-002 Parameter REG_ADDR_W, default 10: register-file address width; instruction = {opcode[1:0], regA, regB, rd}.
REQ-003 Parameter SCLK_DIV, default 2: clock cycles per SCLK half-period; legal range >= 1.
REQ-004 clock  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 instr  in  2+3*REG_ADDR_W  instruction word {opcode, regA, regB, rd}, MSB first.
REQ-007 instr_valid  in  1  instruction present.
REQ-008 instr_ready  out  1  sequencer idle and able to accept.
REQ-009 busy  out  1  high from acceptance until the write-back cycle inclusive.
REQ-010 done  out  1  one-cycle pulse coincident with rf_we.
REQ-011 rf_raddr  out  REG_ADDR_W  register-file read address; read data valid one cycle later.
REQ-012 rf_rdata  in  DATA_W  register-file read data.
REQ-013 rf_we / rf_waddr / rf_wdata  out  1 / REG_ADDR_W / DATA_W  register-file write port.
REQ-014 spi_cs_n / spi_sclk / spi_mosi  out  1 each  SPI master outputs to the ALU.
REQ-015 spi_miso  in  1  SPI serial result from the ALU.

Function
REQ-016 States SHALL be IDLE, RD_A, RD_B, LATCH, XFER, WB; IDLE is the only state with instr_ready=1.
REQ-017 Transfer SHALL occur on the edge where instr_valid && instr_ready; instr captured into an internal register; IDLE->RD_A.
REQ-018 RD_A: rf_raddr=regA; ->RD_B unconditionally.
REQ-019 RD_B: opA<=rf_rdata; rf_raddr=regB; ->LATCH.
REQ-020 LATCH: opB<=rf_rdata; TX shift register loaded with {opcode, opA, opB} (2+2*DATA_W bits); spi_cs_n driven 0 on exit; ->XFER.
REQ-021 XFER: exactly 3*DATA_W+2 SCLK periods (98 at default), each 2*SCLK_DIV clocks, SCLK idle low (SPI mode 0).
REQ-022 spi_mosi SHALL present TX bits MSB first, valid before the first rising SCLK and updated only after each falling SCLK; after the 2+2*DATA_W-th bit spi_mosi SHALL be 0.
REQ-023 spi_miso SHALL be sampled on the rising SCLK of periods 2*DATA_W+3 .. 3*DATA_W+2, shifted in MSB first into the result register; earlier miso values ignored.
REQ-024 After the last falling SCLK, spi_cs_n SHALL return to 1 and state ->WB; XFER lasts exactly 2*SCLK_DIV*(3*DATA_W+2) clocks.
REQ-025 WB: rf_we=1, rf_waddr=rd, rf_wdata=result, done=1 for exactly one cycle; ->IDLE.
REQ-026 Latency: with acceptance cycle = 0, rf_we SHALL be high in cycle 3+2*SCLK_DIV*(3*DATA_W+2) (395 at defaults).
REQ-027 instr_valid and instr changes while busy SHALL be ignored; no queueing.
REQ-028 Back-to-back: instr_ready high the cycle after WB; a new instruction accepted there SHALL see the just-written value.
REQ-029 regA, regB, rd may be equal; both operands SHALL be read before the write-back (read-before-write).
REQ-030 Opcode SHALL be forwarded unmodified; the sequencer performs no arithmetic on operands or result.
REQ-031 rf_we SHALL never assert outside WB; rf_raddr holds its last value outside RD_A/RD_B.

Reset
REQ-032 On reset=0, asynchronously: state=IDLE, instr_ready=1, busy=0, done=0, rf_we=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, internal shift/result registers=0.
REQ-033 Reset mid-operation SHALL abort the frame with no register-file write; first acceptance possible on the first rising edge after reset releases.

Verification
REQ-034 ADD, regA=1 (5), regB=2 (3), rd=3, ALU model returns 8 -> single rf_we with waddr=3, wdata=8 in cycle 395, done coincident.
REQ-035 SUB, opA=0xFFFF_0000, opB=0x0000_FFFF -> captured mosi stream = 2'b01, then opA, then opB MSB first; 98 SCLK periods; cs_n low only during XFER.
REQ-036 Seven instructions with regA=regB=rd=1023 issued back-to-back -> each reads prior written value; instr_ready high exactly one cycle after each done.
REQ-037 instr_valid pulsed with a different instr during XFER -> ignored; rd and wdata of the in-flight op unchanged.
REQ-038 reset=0 for 1 cycle at SCLK period 50 -> cs_n=1, sclk=0, no rf_we; next instruction completes normally.
REQ-039 SCLK_DIV=1 build, AND opA=0xF0F0_F0F0, opB=0xFF00_FF00 -> rf_we in cycle 199, wdata=ALU-model 0xF000_F000.
